// File: rtl/falu_issue_queue_pkg.sv
// Shared FP issue-queue types: the per-entry op record, the default queue depth
// and the writeback wakeup match helper.
`include "define.v"

package falu_issue_queue_pkg;

  localparam int FALU_IQ_DEPTH = 4;
  localparam int FALU_WIDTH    = 32;

  typedef struct packed {
    logic [`MicOperateCode] mic_op;
    logic [`InstAddrBus]    inst_addr;
    logic                   pred;
    logic [`ArchRegBUs]     rd_addr;
  } falu_iq_pay_t;

  // A writeback only wakes a source that is still waiting on that register.
  function automatic logic wb_hit(input logic               wb_vld,
                                  input logic [`ArchRegBUs] wb_addr,
                                  input logic [`ArchRegBUs] src_addr,
                                  input logic               src_rdy);
    return wb_vld && !src_rdy && (wb_addr == src_addr);
  endfunction

endpackage

// File: rtl/define.v
// Shared machine-wide field widths: micro-op code, instruction address and
// architectural register index.
`ifndef FALU_DEFINE_V
`define FALU_DEFINE_V
`define MicOperateCode 7:0
`define InstAddrBus    31:0
`define ArchRegBUs     4:0
`endif

// File: rtl/falu_iq_entry.sv
// One issue-queue slot: holds an op, snoops the writeback bus for its own
// not-ready sources and captures the data on a match.
module falu_iq_entry
  import falu_issue_queue_pkg::*;
#(
  parameter int WIDTH_FALU = FALU_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic                    i_load,
  input  logic                    i_clear,
  input  falu_iq_pay_t            i_pay,
  input  logic [WIDTH_FALU-1:0]   i_jump,
  input  logic                    i_src1_rdy,
  input  logic                    i_src2_rdy,
  input  logic [`ArchRegBUs]      i_src1_addr,
  input  logic [`ArchRegBUs]      i_src2_addr,
  input  logic [2*WIDTH_FALU-1:0] i_src1_dat,
  input  logic [2*WIDTH_FALU-1:0] i_src2_dat,
  input  logic                    i_wb_vld,
  input  logic [`ArchRegBUs]      i_wb_addr,
  input  logic [2*WIDTH_FALU-1:0] i_wb_dat,
  output logic                    o_rdy,
  output falu_iq_pay_t            o_pay,
  output logic [WIDTH_FALU-1:0]   o_jump,
  output logic [2*WIDTH_FALU-1:0] o_src1_dat,
  output logic [2*WIDTH_FALU-1:0] o_src2_dat
);

  logic                    r_vld;
  falu_iq_pay_t            r_pay;
  logic [WIDTH_FALU-1:0]   r_jump;
  logic                    r_s1_rdy;
  logic                    r_s2_rdy;
  logic [`ArchRegBUs]      r_s1_addr;
  logic [`ArchRegBUs]      r_s2_addr;
  logic [2*WIDTH_FALU-1:0] r_s1_dat;
  logic [2*WIDTH_FALU-1:0] r_s2_dat;

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = r_vld && wb_hit(i_wb_vld, i_wb_addr, r_s1_addr, r_s1_rdy);
  assign w_hit2 = r_vld && wb_hit(i_wb_vld, i_wb_addr, r_s2_addr, r_s2_rdy);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld     <= 1'b0;
      r_pay     <= '0;
      r_jump    <= '0;
      r_s1_rdy  <= 1'b0;
      r_s2_rdy  <= 1'b0;
      r_s1_addr <= '0;
      r_s2_addr <= '0;
      r_s1_dat  <= '0;
      r_s2_dat  <= '0;
    end else if (i_flush) begin
      r_vld    <= 1'b0;
      r_s1_rdy <= 1'b0;
      r_s2_rdy <= 1'b0;
    end else if (i_load) begin
      r_vld     <= 1'b1;
      r_pay     <= i_pay;
      r_jump    <= i_jump;
      r_s1_rdy  <= i_src1_rdy;
      r_s2_rdy  <= i_src2_rdy;
      r_s1_addr <= i_src1_addr;
      r_s2_addr <= i_src2_addr;
      r_s1_dat  <= i_src1_dat;
      r_s2_dat  <= i_src2_dat;
    end else begin
      if (i_clear) r_vld <= 1'b0;
      if (w_hit1) begin
        r_s1_rdy <= 1'b1;
        r_s1_dat <= i_wb_dat;
      end
      if (w_hit2) begin
        r_s2_rdy <= 1'b1;
        r_s2_dat <= i_wb_dat;
      end
    end
  end

  assign o_rdy      = r_vld && r_s1_rdy && r_s2_rdy;
  assign o_pay      = r_pay;
  assign o_jump     = r_jump;
  assign o_src1_dat = r_s1_dat;
  assign o_src2_dat = r_s2_dat;

endmodule

// File: rtl/falu_issue_queue.sv
// In-order FP ALU issue queue with writeback wakeup; only the head issues, into a registered output.
// FALU_IQ_ENQ_BYPASS_EN lets a ready op hitting an empty queue go straight to the output register.
module falu_issue_queue
  import falu_issue_queue_pkg::*;
#(
  parameter int DEPTH      = FALU_IQ_DEPTH,
  parameter int WIDTH_FALU = FALU_WIDTH
) (
  input  logic                    Clk,
  input  logic                    Rest,
  input  logic                    Flush,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [`MicOperateCode]  InMicOperate,
  input  logic [`InstAddrBus]     InInstAddr,
  input  logic                    InPredictValue,
  input  logic [WIDTH_FALU-1:0]   InJumpOffset,
  input  logic [`ArchRegBUs]      InRdAddr,
  input  logic [2*WIDTH_FALU-1:0] InSrc1Data,
  input  logic [2*WIDTH_FALU-1:0] InSrc2Data,
  input  logic                    InSrc1Ready,
  input  logic                    InSrc2Ready,
  input  logic [`ArchRegBUs]      InSrc1Addr,
  input  logic [`ArchRegBUs]      InSrc2Addr,
  input  logic                    WbValid,
  input  logic [`ArchRegBUs]      WbAddr,
  input  logic [2*WIDTH_FALU-1:0] WbData,
  output logic                    IssueValid,
  output logic [`MicOperateCode]  FAluMicOperate,
  output logic [`InstAddrBus]     FaluInstAddr,
  output logic                    FpredictValue,
  output logic [WIDTH_FALU-1:0]   FJumpOffset,
  output logic [2*WIDTH_FALU-1:0] FArchRegister1,
  output logic [2*WIDTH_FALU-1:0] FArchRegister2,
  output logic [`ArchRegBUs]      OutRdaddr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DW    = 2 * WIDTH_FALU;

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic            w_enq;
  logic            w_enq_q;
  logic            w_bypass;
  logic            w_issue;
  logic            w_in_hit1;
  logic            w_in_hit2;
  logic            w_in_s1_rdy;
  logic            w_in_s2_rdy;
  logic [DW-1:0]   w_in_s1_dat;
  logic [DW-1:0]   w_in_s2_dat;
  falu_iq_pay_t    w_in_pay;

  logic                  w_e_rdy    [DEPTH];
  falu_iq_pay_t          w_e_pay    [DEPTH];
  logic [WIDTH_FALU-1:0] w_e_jump   [DEPTH];
  logic [DW-1:0]         w_e_s1_dat [DEPTH];
  logic [DW-1:0]         w_e_s2_dat [DEPTH];

  assign InReady = (r_count < CNT_W'(DEPTH));
  assign w_enq   = InValid && InReady && !Flush;

  // Same-cycle wakeup is folded into the incoming op once, shared by every slot and the bypass.
  assign w_in_hit1   = wb_hit(WbValid, WbAddr, InSrc1Addr, InSrc1Ready);
  assign w_in_hit2   = wb_hit(WbValid, WbAddr, InSrc2Addr, InSrc2Ready);
  assign w_in_s1_rdy = InSrc1Ready || w_in_hit1;
  assign w_in_s2_rdy = InSrc2Ready || w_in_hit2;
  assign w_in_s1_dat = w_in_hit1 ? WbData : InSrc1Data;
  assign w_in_s2_dat = w_in_hit2 ? WbData : InSrc2Data;

  assign w_in_pay.mic_op    = InMicOperate;
  assign w_in_pay.inst_addr = InInstAddr;
  assign w_in_pay.pred      = InPredictValue;
  assign w_in_pay.rd_addr   = InRdAddr;

`ifdef FALU_IQ_ENQ_BYPASS_EN
  assign w_bypass = w_enq && (r_count == '0) && w_in_s1_rdy && w_in_s2_rdy;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_enq_q = w_enq && !w_bypass;
  assign w_issue = w_e_rdy[r_head] && !Flush;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    falu_iq_entry #(
      .WIDTH_FALU (WIDTH_FALU)
    ) u_entry (
      .i_clk       (Clk),
      .i_rst       (Rest),
      .i_flush     (Flush),
      .i_load      (w_enq_q && (r_tail == PTR_W'(g))),
      .i_clear     (w_issue && (r_head == PTR_W'(g))),
      .i_pay       (w_in_pay),
      .i_jump      (InJumpOffset),
      .i_src1_rdy  (w_in_s1_rdy),
      .i_src2_rdy  (w_in_s2_rdy),
      .i_src1_addr (InSrc1Addr),
      .i_src2_addr (InSrc2Addr),
      .i_src1_dat  (w_in_s1_dat),
      .i_src2_dat  (w_in_s2_dat),
      .i_wb_vld    (WbValid),
      .i_wb_addr   (WbAddr),
      .i_wb_dat    (WbData),
      .o_rdy       (w_e_rdy[g]),
      .o_pay       (w_e_pay[g]),
      .o_jump      (w_e_jump[g]),
      .o_src1_dat  (w_e_s1_dat[g]),
      .o_src2_dat  (w_e_s2_dat[g])
    );
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (Flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_issue);
      r_tail  <= r_tail + PTR_W'(w_enq_q);
      r_count <= r_count + CNT_W'(w_enq_q) - CNT_W'(w_issue);
    end
  end

  always_ff @(posedge Clk or posedge Rest) begin
    if (Rest) begin
      IssueValid     <= 1'b0;
      FAluMicOperate <= '0;
      FaluInstAddr   <= '0;
      FpredictValue  <= 1'b0;
      FJumpOffset    <= '0;
      FArchRegister1 <= '0;
      FArchRegister2 <= '0;
      OutRdaddr      <= '0;
    end else if (Flush) begin
      IssueValid <= 1'b0;
    end else if (w_issue) begin
      IssueValid     <= 1'b1;
      FAluMicOperate <= w_e_pay[r_head].mic_op;
      FaluInstAddr   <= w_e_pay[r_head].inst_addr;
      FpredictValue  <= w_e_pay[r_head].pred;
      FJumpOffset    <= w_e_jump[r_head];
      FArchRegister1 <= w_e_s1_dat[r_head];
      FArchRegister2 <= w_e_s2_dat[r_head];
      OutRdaddr      <= w_e_pay[r_head].rd_addr;
    end else if (w_bypass) begin
      IssueValid     <= 1'b1;
      FAluMicOperate <= InMicOperate;
      FaluInstAddr   <= InInstAddr;
      FpredictValue  <= InPredictValue;
      FJumpOffset    <= InJumpOffset;
      FArchRegister1 <= w_in_s1_dat;
      FArchRegister2 <= w_in_s2_dat;
      OutRdaddr      <= InRdAddr;
    end else begin
      IssueValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_falu_issue_queue.sv
// Directed bench for falu_issue_queue: issue latency, wakeup, full queue, ordering, flush, reset.
`include "define.v"

module tb_falu_issue_queue;

`ifdef FALU_IQ_ENQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic                   Clk = 1'b0;
  logic                   Rest;
  logic                   Flush;
  logic                   InValid;
  logic                   InReady;
  logic [`MicOperateCode] InMicOperate;
  logic [`InstAddrBus]    InInstAddr;
  logic                   InPredictValue;
  logic [31:0]            InJumpOffset;
  logic [`ArchRegBUs]     InRdAddr;
  logic [63:0]            InSrc1Data;
  logic [63:0]            InSrc2Data;
  logic                   InSrc1Ready;
  logic                   InSrc2Ready;
  logic [`ArchRegBUs]     InSrc1Addr;
  logic [`ArchRegBUs]     InSrc2Addr;
  logic                   WbValid;
  logic [`ArchRegBUs]     WbAddr;
  logic [63:0]            WbData;
  logic                   IssueValid;
  logic [`MicOperateCode] FAluMicOperate;
  logic [`InstAddrBus]    FaluInstAddr;
  logic                   FpredictValue;
  logic [31:0]            FJumpOffset;
  logic [63:0]            FArchRegister1;
  logic [63:0]            FArchRegister2;
  logic [`ArchRegBUs]     OutRdaddr;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  falu_issue_queue dut (
    .Clk            (Clk),
    .Rest           (Rest),
    .Flush          (Flush),
    .InValid        (InValid),
    .InReady        (InReady),
    .InMicOperate   (InMicOperate),
    .InInstAddr     (InInstAddr),
    .InPredictValue (InPredictValue),
    .InJumpOffset   (InJumpOffset),
    .InRdAddr       (InRdAddr),
    .InSrc1Data     (InSrc1Data),
    .InSrc2Data     (InSrc2Data),
    .InSrc1Ready    (InSrc1Ready),
    .InSrc2Ready    (InSrc2Ready),
    .InSrc1Addr     (InSrc1Addr),
    .InSrc2Addr     (InSrc2Addr),
    .WbValid        (WbValid),
    .WbAddr         (WbAddr),
    .WbData         (WbData),
    .IssueValid     (IssueValid),
    .FAluMicOperate (FAluMicOperate),
    .FaluInstAddr   (FaluInstAddr),
    .FpredictValue  (FpredictValue),
    .FJumpOffset    (FJumpOffset),
    .FArchRegister1 (FArchRegister1),
    .FArchRegister2 (FArchRegister2),
    .OutRdaddr      (OutRdaddr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] mic, input logic [4:0] rd,
                        input logic s1r, input logic [4:0] s1a, input logic [63:0] s1d,
                        input logic s2r, input logic [4:0] s2a, input logic [63:0] s2d);
    InValid        = 1'b1;
    InMicOperate   = mic;
    InInstAddr     = {24'h0, mic};
    InPredictValue = mic[0];
    InJumpOffset   = {24'h0, mic};
    InRdAddr       = rd;
    InSrc1Ready    = s1r;
    InSrc1Addr     = s1a;
    InSrc1Data     = s1d;
    InSrc2Ready    = s2r;
    InSrc2Addr     = s2a;
    InSrc2Data     = s2d;
  endtask

  task automatic set_wb(input logic [4:0] a, input logic [63:0] d);
    WbValid = 1'b1;
    WbAddr  = a;
    WbData  = d;
  endtask

  task automatic clr_in;
    InValid = 1'b0;
  endtask

  task automatic clr_wb;
    WbValid = 1'b0;
    WbAddr  = '0;
    WbData  = '0;
  endtask

  initial begin
    Rest = 1'b1;
    Flush = 1'b0;
    set_op(8'h00, 5'd0, 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
    clr_in();
    clr_wb();
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_iv", IssueValid, 1'b0);
    chk("rst_r1", FArchRegister1, 64'h0);
    chk("rst_mic", FAluMicOperate, 8'h00);
    chk("rst_rd", OutRdaddr, 5'd0);
    Rest = 1'b0;
    step();
    chk("rst_inrdy", InReady, 1'b1);

    // Both sources ready, queue empty.
    set_op(8'h11, 5'd3, 1'b1, 5'd1, 64'hAAAA0001, 1'b1, 5'd2, 64'hBBBB0002);
    step();
    clr_in();
    chk("t1_iv_c1", IssueValid, BYP);
    step();
    chk("t1_iv_c2", IssueValid, !BYP);
    chk("t1_r1", FArchRegister1, 64'hAAAA0001);
    chk("t1_r2", FArchRegister2, 64'hBBBB0002);
    chk("t1_rd", OutRdaddr, 5'd3);
    chk("t1_mic", FAluMicOperate, 8'h11);
    step();
    chk("t1_iv_done", IssueValid, 1'b0);
    chk("t1_r1_hold", FArchRegister1, 64'hAAAA0001);

    // Src1 waits on r5, woken two cycles after enqueue.
    set_op(8'h22, 5'd7, 1'b0, 5'd5, 64'h0, 1'b1, 5'd6, 64'h40000000);
    step();
    clr_in();
    chk("t2_iv_c1", IssueValid, 1'b0);
    step();
    chk("t2_iv_c2", IssueValid, 1'b0);
    set_wb(5'd5, 64'h3F800000);
    step();
    clr_wb();
    chk("t2_iv_wake", IssueValid, 1'b0);
    step();
    chk("t2_iv", IssueValid, 1'b1);
    chk("t2_r1", FArchRegister1, 64'h3F800000);
    chk("t2_r2", FArchRegister2, 64'h40000000);
    chk("t2_rd", OutRdaddr, 5'd7);
    step();
    chk("t2_iv_done", IssueValid, 1'b0);

    // Fill the queue with blocked ops; a fifth is refused.
    for (int i = 0; i < 4; i++) begin
      set_op(8'h30 + 8'(i), 5'(i), 1'b0, 5'd10 + 5'(i), 64'h0, 1'b1, 5'd2, 64'h100 + 64'(i));
      step();
    end
    clr_in();
    chk("t3_full", InReady, 1'b0);
    set_op(8'h55, 5'd9, 1'b1, 5'd1, 64'h55, 1'b1, 5'd2, 64'h56);
    step();
    clr_in();
    chk("t3_full_hold", InReady, 1'b0);
    chk("t3_no_iv", IssueValid, 1'b0);
    set_wb(5'd10, 64'hC0DE);
    step();
    clr_wb();
    chk("t3_wake_iv", IssueValid, 1'b0);
    chk("t3_wake_rdy", InReady, 1'b0);
    step();
    chk("t3_iv", IssueValid, 1'b1);
    chk("t3_mic", FAluMicOperate, 8'h30);
    chk("t3_r1", FArchRegister1, 64'hC0DE);
    chk("t3_inrdy", InReady, 1'b1);
    step();
    chk("t3_iv_done", IssueValid, 1'b0);

    // Flush with three queued and the head about to issue.
    set_wb(5'd11, 64'hF00D);
    step();
    clr_wb();
    Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("t5_iv", IssueValid, 1'b0);
    chk("t5_inrdy", InReady, 1'b1);
    set_wb(5'd12, 64'hBEEF);
    step();
    clr_wb();
    step();
    chk("t5_no_iv", IssueValid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_op(8'h40 + 8'(i), 5'(i), 1'b0, 5'd20 + 5'(i), 64'h0, 1'b0, 5'd24, 64'h0);
      step();
      if (i == 2) chk("t5_cnt3", InReady, 1'b1);
    end
    clr_in();
    chk("t5_cnt4", InReady, 1'b0);
    Flush = 1'b1;
    step();
    Flush = 1'b0;

    // Blocked head holds back a ready second entry.
    set_op(8'hA1, 5'd1, 1'b0, 5'd20, 64'h0, 1'b1, 5'd2, 64'h2);
    step();
    set_op(8'hB2, 5'd2, 1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22);
    step();
    clr_in();
    chk("t4_hold0", IssueValid, 1'b0);
    step();
    chk("t4_hold1", IssueValid, 1'b0);
    set_wb(5'd20, 64'h77);
    step();
    clr_wb();
    chk("t4_hold2", IssueValid, 1'b0);
    step();
    chk("t4_a_iv", IssueValid, 1'b1);
    chk("t4_a_mic", FAluMicOperate, 8'hA1);
    chk("t4_a_r1", FArchRegister1, 64'h77);
    step();
    chk("t4_b_iv", IssueValid, 1'b1);
    chk("t4_b_mic", FAluMicOperate, 8'hB2);
    chk("t4_b_r1", FArchRegister1, 64'h11);
    step();
    chk("t4_iv_done", IssueValid, 1'b0);

    // Both sources wait on r6, woken in the enqueue cycle.
    set_op(8'h66, 5'd9, 1'b0, 5'd6, 64'h0, 1'b0, 5'd6, 64'h0);
    set_wb(5'd6, 64'h12345678);
    step();
    clr_in();
    clr_wb();
    chk("t6_iv_c1", IssueValid, BYP);
    step();
    chk("t6_iv_c2", IssueValid, !BYP);
    chk("t6_r1", FArchRegister1, 64'h12345678);
    chk("t6_r2", FArchRegister2, 64'h12345678);
    step();

    // Reset lands mid-burst, between clock edges.
    set_op(8'h71, 5'd4, 1'b1, 5'd1, 64'h71, 1'b1, 5'd2, 64'h72);
    step();
    set_op(8'h72, 5'd5, 1'b1, 5'd1, 64'h81, 1'b1, 5'd2, 64'h82);
    step();
    set_op(8'h73, 5'd6, 1'b1, 5'd1, 64'h91, 1'b1, 5'd2, 64'h92);
    chk("t7_iv_pre", IssueValid, 1'b1);
    #3;
    Rest = 1'b1;
    #1;
    chk("t7_iv_rst", IssueValid, 1'b0);
    chk("t7_r1_rst", FArchRegister1, 64'h0);
    chk("t7_mic_rst", FAluMicOperate, 8'h00);
    chk("t7_rd_rst", OutRdaddr, 5'd0);
    clr_in();
    @(posedge Clk);
    #1;
    Rest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t7_no_iv", IssueValid, 1'b0);
    end
    chk("t7_inrdy", InReady, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
